// File: rtl/mips_core_pkg.sv
// Shared core definitions: default structure sizes and the commit FSM encoding.
package mips_core_pkg;

  localparam int unsigned AL_SIZE_DEFAULT     = 64;
  localparam int unsigned COMMIT_WIN_DEFAULT  = 4;
  localparam int unsigned LSQ_SIZE_DEFAULT    = 16;
  localparam int unsigned BRANCH_NUM_DEFAULT  = 8;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } commit_state_e;

endpackage

// File: rtl/commit_window_scan.sv
// Combinational commit-window scan: finds the longest eligible in-order prefix
// starting at the oldest active-list entry and reports per-slot class bits and
// per-class counts for the committed instructions.
module commit_window_scan
  import mips_core_pkg::*;
#(
  parameter int unsigned ACTIVE_LIST_SIZE   = AL_SIZE_DEFAULT,
  parameter int unsigned COMMIT_WINDOW_SIZE = COMMIT_WIN_DEFAULT,
  localparam int unsigned AL_W  = $clog2(ACTIVE_LIST_SIZE),
  localparam int unsigned CNT_W = $clog2(COMMIT_WINDOW_SIZE + 1)
) (
  input  logic [AL_W-1:0]               base_i,
  input  logic [ACTIVE_LIST_SIZE-1:0]   ready_i,
  input  logic [ACTIVE_LIST_SIZE-1:0]   avail_i,
  input  logic [ACTIVE_LIST_SIZE-1:0]   load_i,
  input  logic [ACTIVE_LIST_SIZE-1:0]   store_i,
  input  logic [ACTIVE_LIST_SIZE-1:0]   branch_i,
  input  logic                          block_all_i,
  input  logic                          block_store_i,
  output logic [CNT_W-1:0]              len_o,
  output logic [COMMIT_WINDOW_SIZE-1:0] load_valid_o,
  output logic [COMMIT_WINDOW_SIZE-1:0] store_valid_o,
  output logic [COMMIT_WINDOW_SIZE-1:0] branch_valid_o,
  output logic [CNT_W-1:0]              load_cnt_o,
  output logic [CNT_W-1:0]              store_cnt_o,
  output logic [CNT_W-1:0]              branch_cnt_o
);

  logic            open_s;
  logic            store_seen_s;
  logic            elig_s;
  logic [AL_W-1:0] idx_s;

  // Walk the window in age order; the first ineligible slot closes the prefix.
  always_comb begin
    open_s         = ~block_all_i;
    store_seen_s   = 1'b0;
    elig_s         = 1'b0;
    idx_s          = base_i;
    len_o          = '0;
    load_valid_o   = '0;
    store_valid_o  = '0;
    branch_valid_o = '0;
    load_cnt_o     = '0;
    store_cnt_o    = '0;
    branch_cnt_o   = '0;
    for (int unsigned i = 0; i < COMMIT_WINDOW_SIZE; i++) begin
      idx_s  = base_i + AL_W'(i);
      elig_s = ~avail_i[idx_s] & ready_i[idx_s];
      // At most one store per cycle, and none while a store is still outstanding.
      if (store_i[idx_s] && (block_store_i || store_seen_s))
        elig_s = 1'b0;
      if (open_s && elig_s) begin
        len_o             = len_o + CNT_W'(1);
        load_valid_o[i]   = load_i[idx_s];
        store_valid_o[i]  = store_i[idx_s];
        branch_valid_o[i] = branch_i[idx_s];
        if (load_i[idx_s])   load_cnt_o   = load_cnt_o + CNT_W'(1);
        if (store_i[idx_s])  store_cnt_o  = store_cnt_o + CNT_W'(1);
        if (branch_i[idx_s]) branch_cnt_o = branch_cnt_o + CNT_W'(1);
        if (store_i[idx_s])  store_seen_s = 1'b1;
      end else begin
        open_s = 1'b0;
      end
    end
  end

endmodule

// File: rtl/commit_unit.sv
// In-order commit unit: retires up to COMMIT_WINDOW_SIZE completed instructions
// per cycle, advances the retirement pointers, and serialises committed stores
// to the data cache through a RUN / STORE_WAIT / FLUSH state machine.
module commit_unit
  import mips_core_pkg::*;
#(
  parameter int unsigned ACTIVE_LIST_SIZE   = AL_SIZE_DEFAULT,
  parameter int unsigned COMMIT_WINDOW_SIZE = COMMIT_WIN_DEFAULT,
  parameter int unsigned LOAD_STORE_SIZE    = LSQ_SIZE_DEFAULT,
  parameter int unsigned BRANCH_NUM         = BRANCH_NUM_DEFAULT,
  localparam int unsigned AL_W  = $clog2(ACTIVE_LIST_SIZE),
  localparam int unsigned WIN_W = $clog2(COMMIT_WINDOW_SIZE),
  localparam int unsigned LS_W  = $clog2(LOAD_STORE_SIZE),
  localparam int unsigned BR_W  = $clog2(BRANCH_NUM),
  localparam int unsigned CNT_W = $clog2(COMMIT_WINDOW_SIZE + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ACTIVE_LIST_SIZE-1:0]   ready_to_commit,
  input  logic [ACTIVE_LIST_SIZE-1:0]   entry_available_bit,
  input  logic [ACTIVE_LIST_SIZE-1:0]   is_load,
  input  logic [ACTIVE_LIST_SIZE-1:0]   is_store,
  input  logic [ACTIVE_LIST_SIZE-1:0]   is_branch,
  input  logic                          branch_miss,
  input  logic                          store_ack,
  output logic                          commit_valid,
  output logic [WIN_W-1:0]              last_valid_commit_idx,
  output logic [COMMIT_WINDOW_SIZE-1:0] load_valid,
  output logic [COMMIT_WINDOW_SIZE-1:0] store_valid,
  output logic [COMMIT_WINDOW_SIZE-1:0] branch_valid,
  output logic [AL_W-1:0]               oldest_inst_pointer,
  output logic [LS_W-1:0]               load_commit_pointer,
  output logic [LS_W-1:0]               store_commit_pointer,
  output logic [BR_W-1:0]               branch_read_pointer,
  output logic                          store_req,
  output logic [LS_W-1:0]               store_req_index
);

  commit_state_e   state_q, state_d;
  logic [AL_W-1:0] oldest_q, oldest_d;
  logic [LS_W-1:0] load_ptr_q, load_ptr_d;
  logic [LS_W-1:0] store_ptr_q, store_ptr_d;
  logic [BR_W-1:0] branch_ptr_q, branch_ptr_d;
  logic            store_req_q, store_req_d;
  logic [LS_W-1:0] store_idx_q, store_idx_d;

  logic [CNT_W-1:0] len_s, load_cnt_s, store_cnt_s, branch_cnt_s;
  logic             block_all_s;

  assign block_all_s = rst_n | branch_miss | (state_q == FLUSH);

  commit_window_scan #(
    .ACTIVE_LIST_SIZE   (ACTIVE_LIST_SIZE),
    .COMMIT_WINDOW_SIZE (COMMIT_WINDOW_SIZE)
  ) u_scan (
    .base_i         (oldest_q),
    .ready_i        (ready_to_commit),
    .avail_i        (entry_available_bit),
    .load_i         (is_load),
    .store_i        (is_store),
    .branch_i       (is_branch),
    .block_all_i    (block_all_s),
    .block_store_i  (state_q == STORE_WAIT),
    .len_o          (len_s),
    .load_valid_o   (load_valid),
    .store_valid_o  (store_valid),
    .branch_valid_o (branch_valid),
    .load_cnt_o     (load_cnt_s),
    .store_cnt_o    (store_cnt_s),
    .branch_cnt_o   (branch_cnt_s)
  );

  assign commit_valid          = (len_s != '0);
  assign last_valid_commit_idx = commit_valid ? WIN_W'(len_s - CNT_W'(1)) : '0;

  assign oldest_inst_pointer  = oldest_q;
  assign load_commit_pointer  = load_ptr_q;
  assign store_commit_pointer = store_ptr_q;
  assign branch_read_pointer  = branch_ptr_q;
  assign store_req            = store_req_q;
  assign store_req_index      = store_idx_q;

  // Pointer advance by the committed counts; natural wrap at each size.
  always_comb begin
    oldest_d     = oldest_q + AL_W'(len_s);
    load_ptr_d   = load_ptr_q + LS_W'(load_cnt_s);
    store_ptr_d  = store_ptr_q + LS_W'(store_cnt_s);
    branch_ptr_d = branch_ptr_q + BR_W'(branch_cnt_s);
  end

  // Next-state and store-request logic.
  always_comb begin
    state_d     = state_q;
    store_req_d = store_req_q;
    store_idx_d = store_idx_q;
    unique case (state_q)
      RUN: begin
        if (branch_miss) begin
          state_d = FLUSH;
        end else if (store_cnt_s != '0) begin
          // Only one store can commit per cycle, so its index is the pre-advance pointer.
          state_d     = STORE_WAIT;
          store_req_d = 1'b1;
          store_idx_d = store_ptr_q;
        end
      end
      STORE_WAIT: begin
        // An ack coinciding with a flush retires the request; otherwise it stays pending.
        if (store_ack) store_req_d = 1'b0;
        if (branch_miss)    state_d = FLUSH;
        else if (store_ack) state_d = RUN;
      end
      FLUSH: begin
        // Pending store survives the flush and is resumed afterwards.
        if (!branch_miss) state_d = store_req_q ? STORE_WAIT : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State and pointer registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= RUN;
      oldest_q     <= '0;
      load_ptr_q   <= '0;
      store_ptr_q  <= '0;
      branch_ptr_q <= '0;
      store_req_q  <= 1'b0;
      store_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      oldest_q     <= oldest_d;
      load_ptr_q   <= load_ptr_d;
      store_ptr_q  <= store_ptr_d;
      branch_ptr_q <= branch_ptr_d;
      store_req_q  <= store_req_d;
      store_idx_q  <= store_idx_d;
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit with hand-computed expected values.
module tb_commit_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ready_to_commit, entry_available_bit, is_load, is_store, is_branch;
  logic        branch_miss, store_ack;
  logic        commit_valid;
  logic [1:0]  last_valid_commit_idx;
  logic [3:0]  load_valid, store_valid, branch_valid;
  logic [5:0]  oldest_inst_pointer;
  logic [3:0]  load_commit_pointer, store_commit_pointer;
  logic [2:0]  branch_read_pointer;
  logic        store_req;
  logic [3:0]  store_req_index;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  commit_unit #(
    .ACTIVE_LIST_SIZE   (64),
    .COMMIT_WINDOW_SIZE (4),
    .LOAD_STORE_SIZE    (16),
    .BRANCH_NUM         (8)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ready_to_commit       (ready_to_commit),
    .entry_available_bit   (entry_available_bit),
    .is_load               (is_load),
    .is_store              (is_store),
    .is_branch             (is_branch),
    .branch_miss           (branch_miss),
    .store_ack             (store_ack),
    .commit_valid          (commit_valid),
    .last_valid_commit_idx (last_valid_commit_idx),
    .load_valid            (load_valid),
    .store_valid           (store_valid),
    .branch_valid          (branch_valid),
    .oldest_inst_pointer   (oldest_inst_pointer),
    .load_commit_pointer   (load_commit_pointer),
    .store_commit_pointer  (store_commit_pointer),
    .branch_read_pointer   (branch_read_pointer),
    .store_req             (store_req),
    .store_req_index       (store_req_index)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_entries();
    ready_to_commit     = '0;
    entry_available_bit = '1;
    is_load             = '0;
    is_store            = '0;
    is_branch           = '0;
  endtask

  task automatic alloc(input int unsigned idx, input bit rdy, input bit ld, input bit st, input bit br);
    entry_available_bit[idx] = 1'b0;
    ready_to_commit[idx]     = rdy;
    is_load[idx]             = ld;
    is_store[idx]            = st;
    is_branch[idx]           = br;
  endtask

  initial begin
    rst_n       = 1'b1;
    branch_miss = 1'b0;
    store_ack   = 1'b0;
    clear_entries();
    for (int unsigned e = 0; e < 4; e++) alloc(e, 1, 0, 0, 0);
    tick();
    tick();
    #1;
    // Reset state and gating of commit while in reset.
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_oldest", 32'(oldest_inst_pointer), 32'd0);
    check("rst_store_req", 32'(store_req), 32'd0);
    check("rst_ptrs", 32'({load_commit_pointer, store_commit_pointer, branch_read_pointer}), 32'd0);

    // Four ready entries, branches at entries 1 and 3.
    rst_n = 1'b0;
    clear_entries();
    alloc(0, 1, 0, 0, 0); alloc(1, 1, 0, 0, 1); alloc(2, 1, 0, 0, 0); alloc(3, 1, 0, 0, 1);
    #1;
    check("full_commit_valid", 32'(commit_valid), 32'd1);
    check("full_idx", 32'(last_valid_commit_idx), 32'd3);
    check("full_branch_valid", 32'(branch_valid), 32'b1010);
    tick();
    check("full_oldest", 32'(oldest_inst_pointer), 32'd4);
    check("full_branch_ptr", 32'(branch_read_pointer), 32'd2);

    // Gap in readiness ends the prefix.
    clear_entries();
    alloc(4, 1, 0, 0, 0); alloc(5, 1, 0, 0, 0); alloc(6, 0, 0, 0, 0); alloc(7, 1, 0, 0, 0);
    #1;
    check("gap_idx", 32'(last_valid_commit_idx), 32'd1);
    tick();
    check("gap_oldest", 32'(oldest_inst_pointer), 32'd6);

    // Retire everything up to entry 62 (14 full windows from 6).
    clear_entries();
    for (int unsigned e = 0; e < 64; e++) alloc(e, 1, 0, 0, 0);
    for (int unsigned c = 0; c < 14; c++) tick();
    check("walk_oldest", 32'(oldest_inst_pointer), 32'd62);

    // Wrap-around window with loads at entries 63 and 0.
    clear_entries();
    alloc(62, 1, 0, 0, 0); alloc(63, 1, 1, 0, 0); alloc(0, 1, 1, 0, 0); alloc(1, 1, 0, 0, 0);
    #1;
    check("wrap_idx", 32'(last_valid_commit_idx), 32'd3);
    check("wrap_load_valid", 32'(load_valid), 32'b0110);
    tick();
    check("wrap_oldest", 32'(oldest_inst_pointer), 32'd2);
    check("wrap_load_ptr", 32'(load_commit_pointer), 32'd2);

    // Stores at slots 0 and 2: only the first store's prefix commits.
    clear_entries();
    alloc(2, 1, 0, 1, 0); alloc(3, 1, 0, 0, 0); alloc(4, 1, 0, 1, 0); alloc(5, 1, 0, 0, 0);
    #1;
    check("st2_idx", 32'(last_valid_commit_idx), 32'd1);
    check("st2_store_valid", 32'(store_valid), 32'b0001);
    tick();
    check("st2_store_req", 32'(store_req), 32'd1);
    check("st2_req_index", 32'(store_req_index), 32'd0);
    check("st2_oldest", 32'(oldest_inst_pointer), 32'd4);
    check("st2_store_ptr", 32'(store_commit_pointer), 32'd1);
    for (int unsigned c = 0; c < 3; c++) begin
      check("stwait_blocked", 32'(commit_valid), 32'd0);
      tick();
      check("stwait_oldest", 32'(oldest_inst_pointer), 32'd4);
    end
    store_ack = 1'b1;
    #1;
    check("ack_same_cycle_blocked", 32'(commit_valid), 32'd0);
    tick();
    store_ack = 1'b0;
    #1;
    check("ack_req_clear", 32'(store_req), 32'd0);
    check("resume_store_valid", 32'(store_valid), 32'b0001);
    check("resume_idx", 32'(last_valid_commit_idx), 32'd1);
    tick();
    check("resume_req", 32'(store_req), 32'd1);
    check("resume_req_index", 32'(store_req_index), 32'd1);
    check("resume_oldest", 32'(oldest_inst_pointer), 32'd6);

    // Non-stores keep committing in STORE_WAIT; the store behind them waits.
    clear_entries();
    alloc(6, 1, 0, 0, 0); alloc(7, 1, 0, 0, 0); alloc(8, 1, 0, 1, 0);
    #1;
    check("stwait_nonstore_idx", 32'(last_valid_commit_idx), 32'd1);
    check("stwait_nonstore_sv", 32'(store_valid), 32'b0000);
    tick();
    check("stwait_nonstore_oldest", 32'(oldest_inst_pointer), 32'd8);

    // Branch miss for two cycles while a store is pending, then one FLUSH cycle.
    clear_entries();
    for (int unsigned e = 8; e < 12; e++) alloc(e, 1, 0, 0, 0);
    branch_miss = 1'b1;
    #1;
    check("miss1_commit_valid", 32'(commit_valid), 32'd0);
    tick();
    check("miss2_commit_valid", 32'(commit_valid), 32'd0);
    tick();
    branch_miss = 1'b0;
    #1;
    check("flush_commit_valid", 32'(commit_valid), 32'd0);
    check("flush_store_req", 32'(store_req), 32'd1);
    check("flush_oldest", 32'(oldest_inst_pointer), 32'd8);
    tick();
    check("post_flush_commit", 32'(commit_valid), 32'd1);
    check("post_flush_idx", 32'(last_valid_commit_idx), 32'd3);
    check("post_flush_store_req", 32'(store_req), 32'd1);
    tick();
    check("post_flush_oldest", 32'(oldest_inst_pointer), 32'd12);

    // Reset while STORE_WAIT abandons the pending store.
    clear_entries();
    for (int unsigned e = 12; e < 16; e++) alloc(e, 1, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check("midrst_commit_valid", 32'(commit_valid), 32'd0);
    tick();
    rst_n = 1'b0;
    clear_entries();
    alloc(0, 1, 0, 1, 0);
    #1;
    check("midrst_store_req", 32'(store_req), 32'd0);
    check("midrst_oldest", 32'(oldest_inst_pointer), 32'd0);
    check("midrst_ptrs", 32'({load_commit_pointer, store_commit_pointer, branch_read_pointer}), 32'd0);
    check("midrst_req_index", 32'(store_req_index), 32'd0);
    check("midrst_run_store", 32'(store_valid), 32'b0001);
    tick();
    check("midrst_new_req", 32'(store_req), 32'd1);
    check("midrst_new_store_ptr", 32'(store_commit_pointer), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
